// File: rtl/bp_pkg.sv
// Shared types and counter arithmetic for the branch history table predictor.
package bp_pkg;

  localparam int CTR_MAX_W = 4;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bp_state_e;

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic logic [CTR_MAX_W-1:0] ctr_init(input int ctr_w);
    return CTR_MAX_W'((1 << (ctr_w - 1)) - 1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_sat_update(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int                   ctr_w
  );
    logic [CTR_MAX_W-1:0] ctr_max;
    ctr_max = CTR_MAX_W'((1 << ctr_w) - 1);
    if (taken) begin
      return (ctr >= ctr_max) ? ctr_max : ctr + CTR_MAX_W'(1);
    end
    return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/bht_ctr_array.sv
// Saturating-counter table: one read-modify-write port, one registered read
// port with write-first bypass so a same-index read sees the post-update value.
module bht_ctr_array
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int CTR_W   = 2,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_init,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  input  logic             rd_en,
  input  logic             rd_force_init,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr
);

  localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(ctr_init(CTR_W));

  logic [CTR_W-1:0] mem [ENTRIES];
  logic [CTR_W-1:0] wr_cur;
  logic [CTR_W-1:0] wr_data;
  logic [CTR_W-1:0] rd_ctr_next;
  logic [CTR_W-1:0] rd_ctr_reg;

  assign wr_cur  = mem[wr_idx];
  assign wr_data = wr_init ? INIT_CTR
                           : CTR_W'(ctr_sat_update(CTR_MAX_W'(wr_cur), wr_taken, CTR_W));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // During the clear sweep the table contents are stale, so reads report the initial value.
  always_comb begin
    rd_ctr_next = mem[rd_idx];
    if (rd_force_init) begin
      rd_ctr_next = INIT_CTR;
    end else if (wr_en && (wr_idx == rd_idx)) begin
      rd_ctr_next = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ctr_reg <= '0;
    end else if (rd_en) begin
      rd_ctr_reg <= rd_ctr_next;
    end
  end

  assign rd_ctr = rd_ctr_reg;

endmodule

// File: rtl/bht_predictor.sv
// Bimodal / gshare branch direction predictor with non-speculative global
// history and a one-entry-per-cycle clear sweep after reset or clr_req.
module bht_predictor
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int CTR_W   = 2,
  parameter  int GHR_W   = 8,
  parameter  int GSHARE  = 1,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_req,
  input  logic [31:0]      pred_pc,
  output logic             pred_vld,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  output logic [CTR_W-1:0] pred_ctr,
  input  logic             upd_vld,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             clr_req,
  output logic             busy
);

  bp_state_e        state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [GHR_W-1:0] ghr_reg, ghr_next;
  logic             pred_vld_reg;
  logic [IDX_W-1:0] pred_idx_reg;

  logic [IDX_W-1:0] hist_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_en;
  logic             wr_init;
  logic [IDX_W-1:0] wr_idx;
  logic             unused_pc_bits;

  // History folded onto the index width: zero-extended or truncated.
  for (genvar gi = 0; gi < IDX_W; gi++) begin : g_hist
    if (gi < GHR_W) begin : g_bit
      assign hist_idx[gi] = ghr_reg[gi];
    end else begin : g_zero
      assign hist_idx[gi] = 1'b0;
    end
  end

  assign rd_idx = (GSHARE != 0) ? (pred_pc[IDX_W+1:2] ^ hist_idx) : pred_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    ghr_next   = ghr_reg;
    wr_en      = 1'b0;
    wr_init    = 1'b0;
    wr_idx     = upd_idx;
    case (state_reg)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_init = 1'b1;
        wr_idx  = ptr_reg;
        if (clr_req) begin
          ptr_next = '0;
          ghr_next = '0;
        end else if (ptr_reg == IDX_W'(ENTRIES - 1)) begin
          state_next = ST_RUN;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + IDX_W'(1);
        end
      end
      default: begin
        // A clear in the same cycle as an update wins and drops the update.
        if (clr_req) begin
          state_next = ST_CLEAR;
          ptr_next   = '0;
          ghr_next   = '0;
        end else if (upd_vld) begin
          wr_en    = 1'b1;
          ghr_next = (ghr_reg << 1) | GHR_W'(upd_taken);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_CLEAR;
      ptr_reg      <= '0;
      ghr_reg      <= '0;
      pred_vld_reg <= 1'b0;
      pred_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      ghr_reg      <= ghr_next;
      pred_vld_reg <= pred_req;
      if (pred_req) begin
        pred_idx_reg <= rd_idx;
      end
    end
  end

  bht_ctr_array #(
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W)
  ) u_ctr_array (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_init       (wr_init),
    .wr_idx        (wr_idx),
    .wr_taken      (upd_taken),
    .rd_en         (pred_req),
    .rd_force_init (state_reg == ST_CLEAR),
    .rd_idx        (rd_idx),
    .rd_ctr        (pred_ctr)
  );

  assign pred_vld   = pred_vld_reg;
  assign pred_idx   = pred_idx_reg;
  assign pred_taken = pred_ctr[CTR_W-1];
  assign busy       = (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench: bimodal and gshare instances share stimulus and are checked
// against a table-of-integers reference model.
module tb_bht_predictor;

  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int GHR_W   = 4;
  localparam int IDX_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pred_req = 1'b0;
  logic [31:0]      pred_pc = '0;
  logic             upd_vld = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic             upd_taken = 1'b0;
  logic             clr_req = 1'b0;

  logic             bi_vld, bi_taken, bi_busy;
  logic [IDX_W-1:0] bi_idx;
  logic [CTR_W-1:0] bi_ctr;
  logic             gs_vld, gs_taken, gs_busy;
  logic [IDX_W-1:0] gs_idx;
  logic [CTR_W-1:0] gs_ctr;

  always #5 clk = ~clk;

  bht_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .GHR_W(GHR_W), .GSHARE(0)) dut_bi (
    .clk(clk), .rst_n(rst_n), .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_vld(bi_vld), .pred_taken(bi_taken), .pred_idx(bi_idx), .pred_ctr(bi_ctr),
    .upd_vld(upd_vld), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .clr_req(clr_req), .busy(bi_busy)
  );

  bht_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .GHR_W(GHR_W), .GSHARE(1)) dut_gs (
    .clk(clk), .rst_n(rst_n), .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_vld(gs_vld), .pred_taken(gs_taken), .pred_idx(gs_idx), .pred_ctr(gs_ctr),
    .upd_vld(upd_vld), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .clr_req(clr_req), .busy(gs_busy)
  );

  typedef struct packed {
    logic             taken;
    logic [IDX_W-1:0] idx;
    logic [CTR_W-1:0] ctr;
  } exp_t;

  exp_t q_bi[$];
  exp_t q_gs[$];
  int   errors = 0;
  int   checks = 0;

  int   model_ctr[ENTRIES];
  int   model_ghr;
  int   clear_left;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic model_restart();
    model_ghr  = 0;
    clear_left = ENTRIES;
    foreach (model_ctr[i]) model_ctr[i] = 1;
  endtask

  function automatic exp_t make_exp(input int idx, input bit in_clear);
    exp_t e;
    e.idx   = IDX_W'(idx);
    e.ctr   = in_clear ? CTR_W'(1) : CTR_W'(model_ctr[idx]);
    e.taken = in_clear ? 1'b0 : (model_ctr[idx] >= 2);
    return e;
  endfunction

  // Applies the current inputs as one clock of the reference behaviour.
  task automatic model_step();
    bit in_clear;
    int pidx;
    int gidx;
    in_clear = (clear_left > 0);
    pidx = int'(pred_pc[5:2]);
    gidx = pidx ^ (model_ghr % 16);
    if (!in_clear && upd_vld && !clr_req) begin
      if (upd_taken) model_ctr[upd_idx] = (model_ctr[upd_idx] == 3) ? 3 : model_ctr[upd_idx] + 1;
      else           model_ctr[upd_idx] = (model_ctr[upd_idx] == 0) ? 0 : model_ctr[upd_idx] - 1;
      model_ghr = (model_ghr * 2 + int'(upd_taken)) % 16;
    end
    if (pred_req) begin
      q_bi.push_back(make_exp(pidx, in_clear));
      q_gs.push_back(make_exp(gidx, in_clear));
    end
    if (clr_req) model_restart();
    else if (in_clear) clear_left--;
  endtask

  task automatic cycle(input bit req, input logic [31:0] pc, input bit upd,
                       input int uidx, input bit ut, input bit clr);
    pred_req  = req;
    pred_pc   = pc;
    upd_vld   = upd;
    upd_idx   = IDX_W'(uidx);
    upd_taken = ut;
    clr_req   = clr;
    @(negedge clk);
    check("busy_bi", int'(bi_busy), int'(clear_left > 0));
    check("busy_gs", int'(gs_busy), int'(clear_left > 0));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic rand_cycle(input bit allow_clr);
    cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, ENTRIES - 1)), 1'($urandom_range(0, 1)),
          allow_clr && ($urandom_range(0, 63) == 0));
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_bi_vld"},   int'(bi_vld),   0);
    check({tag, "_bi_taken"}, int'(bi_taken), 0);
    check({tag, "_bi_idx"},   int'(bi_idx),   0);
    check({tag, "_bi_ctr"},   int'(bi_ctr),   0);
    check({tag, "_bi_busy"},  int'(bi_busy),  1);
    check({tag, "_gs_vld"},   int'(gs_vld),   0);
    check({tag, "_gs_ctr"},   int'(gs_ctr),   0);
    check({tag, "_gs_busy"},  int'(gs_busy),  1);
  endtask

  always @(negedge clk) begin : mon_bi
    exp_t e;
    if (rst_n && bi_vld) begin
      if (q_bi.size() == 0) begin
        check("pred_bi_unexpected", 1, 0);
      end else begin
        e = q_bi.pop_front();
        check("pred_bi_taken", int'(bi_taken), int'(e.taken));
        check("pred_bi_idx",   int'(bi_idx),   int'(e.idx));
        check("pred_bi_ctr",   int'(bi_ctr),   int'(e.ctr));
      end
    end
  end

  always @(negedge clk) begin : mon_gs
    exp_t e;
    if (rst_n && gs_vld) begin
      if (q_gs.size() == 0) begin
        check("pred_gs_unexpected", 1, 0);
      end else begin
        e = q_gs.pop_front();
        check("pred_gs_taken", int'(gs_taken), int'(e.taken));
        check("pred_gs_idx",   int'(gs_idx),   int'(e.idx));
        check("pred_gs_ctr",   int'(gs_ctr),   int'(e.ctr));
      end
    end
  end

  initial begin
    model_restart();
    repeat (3) @(posedge clk);
    #1;
    reset_check("rst");
    rst_n = 1'b1;
    model_restart();

    // Sweep with traffic: updates must be ignored, predictions forced weak-not-taken.
    for (int i = 0; i < ENTRIES; i++) rand_cycle(1'b0);
    cycle(1'b1, $urandom, 1'b0, 0, 1'b0, 1'b0);
    idle(1);

    // Saturate idx 5 upward, then downward, probing after each update.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 5, 1'b1, 1'b0);
      cycle(1'b1, 32'h14, 1'b0, 0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 5, 1'b0, 1'b0);
      cycle(1'b1, 32'h14, 1'b0, 0, 1'b0, 1'b0);
    end

    // Same-cycle read and update of idx 5 (ctr 1 -> 2).
    cycle(1'b0, 32'h0, 1'b1, 5, 1'b1, 1'b0);
    cycle(1'b1, 32'h14, 1'b1, 5, 1'b1, 1'b0);
    idle(1);

    // Clear together with an update: the update to idx 3 must be dropped.
    cycle(1'b0, 32'h0, 1'b1, 3, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 3, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 3, 1'b1, 1'b1);
    idle(ENTRIES);
    for (int i = 0; i < ENTRIES; i++) cycle(1'b1, 32'(i * 4), 1'b0, 0, 1'b0, 1'b0);

    // History T,T,N gives 0110; PC 0 then indexes 6 in gshare.
    cycle(1'b0, 32'h0, 1'b1, 0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    idle(1);

    // Clear restarted mid-sweep.
    cycle(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
    idle(5);
    cycle(1'b1, 32'h24, 1'b1, 9, 1'b1, 1'b1);
    idle(ENTRIES + 1);

    for (int i = 0; i < 600; i++) rand_cycle(1'b1);

    // Asynchronous reset in mid-operation.
    cycle(1'b1, 32'h14, 1'b0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_check("rst_mid");
    q_bi.delete();
    q_gs.delete();
    model_restart();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) rand_cycle(1'b1);
    idle(2);

    check("q_bi_drained", q_bi.size(), 0);
    check("q_gs_drained", q_gs.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL expose parameter ENTRIES, default 64, number of counter entries (power of two, 4..4096); IDX_W = log2(ENTRIES).
REQ-002 SHALL expose parameter CTR_W, default 2, saturating-counter width (1..4).
REQ-003 SHALL expose parameter GHR_W, default 8, global-history length (1..16).
REQ-004 SHALL expose parameter GSHARE, default 1; 0 = bimodal indexing, 1 = gshare indexing.
REQ-005 SHALL use a single clock `clk`, with asynchronous, active-low reset `rst_n`.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 pred_req  input  1  prediction request this cycle.
REQ-009 pred_pc  input  32  branch PC for the request.
REQ-010 pred_vld  output  1  prediction result valid.
REQ-011 pred_taken  output  1  predicted direction.
REQ-012 pred_idx  output  IDX_W  table index used, returned later with the update.
REQ-013 pred_ctr  output  CTR_W  counter value used.
REQ-014 upd_vld  input  1  resolved-branch update this cycle.
REQ-015 upd_idx  input  IDX_W  index previously returned by pred_idx.
REQ-016 upd_taken  input  1  actual outcome.
REQ-017 clr_req  input  1  synchronous single-cycle request to reinitialise table and history.
REQ-018 busy  output  1  high while the clear sweep runs.

Function
REQ-019 Counter encoding SHALL be unsigned; predict taken iff counter MSB = 1; the initial value SHALL be 2^(CTR_W-1)-1 (weakly not-taken, 01 for CTR_W=2).
REQ-020 Update SHALL increment on taken and decrement on not-taken, saturating at 2^CTR_W-1 and 0.
REQ-021 Index SHALL be pred_pc[IDX_W+1:2] when GSHARE=0, XOR-ed with GHR zero-extended or truncated to IDX_W when GSHARE=1.
REQ-022 Prediction latency SHALL be exactly 1 cycle: pred_vld, pred_taken, pred_idx and pred_ctr are registered and valid the cycle after pred_req; pred_vld is low otherwise.
REQ-023 When upd_vld targets the same index being read, the prediction SHALL reflect the post-update counter (write-first bypass).
REQ-024 GHR SHALL shift left one bit on each upd_vld, inserting upd_taken at bit 0; GHR is non-speculative; an index computed in the same cycle uses the pre-shift GHR.
REQ-025 FSM SHALL have states CLEAR and RUN; CLEAR writes the initial value to one entry per cycle from index 0 to ENTRIES-1, then enters RUN; the sweep takes ENTRIES cycles.
REQ-026 busy SHALL be 1 exactly while in CLEAR.
REQ-027 In CLEAR, upd_vld SHALL be ignored (no counter or GHR change), and pred_req SHALL still produce pred_vld with pred_taken=0 and pred_ctr = initial value.
REQ-028 clr_req in RUN SHALL clear GHR to 0 and enter CLEAR at index 0 next cycle; clr_req in CLEAR SHALL restart the sweep at index 0.
REQ-029 clr_req and upd_vld in the same RUN cycle SHALL drop the update.

Reset
REQ-030 rst_n low SHALL immediately force pred_vld=0, pred_taken=0, pred_idx=0, pred_ctr=0, GHR=0, sweep pointer=0, state=CLEAR, busy=1.
REQ-031 After rst_n deasserts, the block SHALL sweep ENTRIES cycles and then enter RUN; the counter array itself is not reset asynchronously.
REQ-032 Reset asserted mid-sweep or mid-operation SHALL restart from REQ-030 with no partial state retained.

Structure
REQ-033 Shared package bp_pkg SHALL hold the FSM state enum, the counter-initial-value function and the saturating-update function.
REQ-034 The counter array with its read bypass SHALL be one sub-module, bht_ctr_array (1 write port, 1 read port, registered read).

Verification
REQ-035 ENTRIES=16, CTR_W=2: reset, then count cycles -> busy high 16 cycles, then low; predict any PC -> taken=0, ctr=1.
REQ-036 GSHARE=0: send 3 taken updates to idx 5 -> ctr 2, then 3, then stays 3; predict PC 0x14 -> taken=1, idx=5, ctr=3.
REQ-037 Send 4 not-taken updates to idx 5 from ctr=3 -> ctr goes 2, 1, 0, 0.
REQ-038 Same-cycle pred_req (PC 0x14) and upd_vld (idx 5, taken, ctr 1) -> prediction next cycle shows ctr=2, taken=1.
REQ-039 GSHARE=1, GHR_W=4: updates taken, taken, not-taken leave GHR=0b0110; predict PC 0x0 -> idx=6.
REQ-040 Assert clr_req in RUN together with upd_vld -> update dropped, busy high 16 cycles, GHR=0, all counters = 1; then assert clr_req mid-sweep -> sweep restarts at 0.
